// File: rtl/lcd_write_arb_if.sv
// Bus bundle between lcd_write_arb, its requesters and the lcd_write byte writer.
// The master modport is the arbiter side; the slave modport is the requester/writer side.
interface lcd_write_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 9
);
  // Handshake: requester i holds req[i], last[i] and its req_data slice stable until
  // the one-cycle ack[i] that retires that word. en_write is a one-cycle start to
  // lcd_write, and wr_done is its one-cycle completion; wr_done is ignored unless a
  // word is in flight.
  logic                      init_done;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wr_done;
  logic [DATA_W-1:0]         data;
  logic                      en_write;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic [2:0]                dbg_state;

  modport master (
    input  init_done, req, last, req_data, wr_done,
    output data, en_write, ack, gnt, busy, dbg_state
  );

  modport slave (
    output init_done, req, last, req_data, wr_done,
    input  data, en_write, ack, gnt, busy, dbg_state
  );
endinterface

// File: rtl/lcd_write_arb.sv
// Burst-locking arbiter sharing one lcd_write SPI byte writer among NUM_REQ requesters.
// Define LCD_ARB_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module lcd_write_arb #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 9
) (
  input logic             sys_clk_50MHz,
  input logic             sys_rst,
  lcd_write_arb_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               en_write_q, en_write_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   win_idx;
`ifdef LCD_ARB_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  // Index 0 (init sequencer) is the only requester allowed before init completes.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req[i] & (bus.init_done | (i == 0));
    end
  end

`ifdef LCD_ARB_RR_EN
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    data_d     = data_q;
    own_d      = own_q;
    last_d     = last_q;
    en_write_d = 1'b0;
    ack_d      = '0;
`ifdef LCD_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          own_d      = win_idx;
          gnt_d      = NUM_REQ'(1) << win_idx;
          data_d     = bus.req_data[int'(win_idx) * DATA_W +: DATA_W];
          en_write_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.wr_done) begin
          last_d  = bus.last[own_q];
          ack_d   = gnt_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (last_q) begin
          gnt_d   = '0;
          state_d = S_IDLE;
`ifdef LCD_ARB_RR_EN
          ptr_d   = own_q;
`endif
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Grant stays locked; a dropped req means the owner abandoned its burst.
        if (bus.req[own_q]) begin
          data_d     = bus.req_data[int'(own_q) * DATA_W +: DATA_W];
          en_write_d = 1'b1;
          state_d    = S_ISSUE;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
`ifdef LCD_ARB_RR_EN
          ptr_d   = own_q;
`endif
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      en_write_q <= 1'b0;
      last_q     <= 1'b0;
      own_q      <= '0;
`ifdef LCD_ARB_RR_EN
      ptr_q      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      en_write_q <= en_write_d;
      last_q     <= last_d;
      own_q      <= own_d;
`ifdef LCD_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.en_write  = en_write_q;
  assign bus.ack       = ack_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_lcd_write_arb.sv
// Self-checking bench for lcd_write_arb: requester queues, an lcd_write latency model
// and a burst-level arbitration model feeding an expected-word scoreboard.
module tb_lcd_write_arb;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 9;
  localparam int IDX_W   = 2;
  localparam int W       = IDX_W + DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd_write_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
  lcd_write_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .sys_clk_50MHz(clk),
    .sys_rst      (rst),
    .bus          (bus)
  );

  // Each requester's pending words: {last, data}
  logic [DATA_W:0]      rq [NUM_REQ][$];
  logic [W-1:0]         exp_q[$];
  logic [NUM_REQ-1:0]   obs_q[$];
  int vectors = 0, errors = 0, cyc = 0, en_count = 0;
  int mptr = NUM_REQ - 1;
  int lcd_min = 0, lcd_max = 3, lcd_cnt = 0;
  bit lcd_busy = 0, word_live = 0, live_mid = 0, ack_due = 0, mid_burst = 0, inj_hold = 0;
  int live_idx = 0, last_ack_cyc = 0, inj_at = -1;

  function automatic bit pending(int i);
    return (rq[i].size() > 0) && (bus.init_done || i == 0);
  endfunction

  function automatic bit pending_any();
    bit p = 0;
    for (int i = 0; i < NUM_REQ; i++) p |= pending(i);
    return p;
  endfunction

  // Burst-level model: pick the owner of the next burst and queue its words.
  task automatic predict_burst();
    int win = -1;
`ifdef LCD_ARB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++)
      if (win < 0 && pending((mptr + k) % NUM_REQ)) win = (mptr + k) % NUM_REQ;
`else
    for (int i = 0; i < NUM_REQ; i++)
      if (win < 0 && pending(i)) win = i;
`endif
    if (win < 0) return;
    for (int j = 0; j < rq[win].size(); j++) begin
      exp_q.push_back({IDX_W'(win), rq[win][j][DATA_W-1:0]});
      if (rq[win][j][DATA_W]) break;
    end
    mptr = win;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        bus.req[i]  = 1'b1;
        bus.last[i] = rq[i][0][DATA_W];
        bus.req_data[i*DATA_W +: DATA_W] = rq[i][0][DATA_W-1:0];
      end else begin
        bus.req[i]  = 1'b0;
        bus.last[i] = 1'b0;
        bus.req_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic step();
    logic [W-1:0]       e;
    logic [NUM_REQ-1:0] exp_ack;
    bit issued = 0;
    bit wr_drv = 0;
    @(posedge clk); #1;
    cyc++;
    exp_ack = ack_due ? (NUM_REQ'(1) << live_idx) : '0;
    vectors++;
    if (bus.ack !== exp_ack) begin
      errors++;
      $display("FAIL ack cyc=%0d got=%b expected=%b", cyc, bus.ack, exp_ack);
    end
    if (ack_due) begin
      mid_burst    = live_mid;
      last_ack_cyc = cyc;
      if (inj_hold && live_mid) inj_at = cyc + 1;
    end
    ack_due = 0;
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.ack[i] === 1'b1 && rq[i].size() > 0) rq[i].delete(0);
    if (bus.en_write === 1'b1) begin
      en_count++;
      if (exp_q.size() == 0) begin
        predict_burst();
        obs_q.push_back(bus.gnt);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en_write cyc=%0d gnt=%b data=%h", cyc, bus.gnt, bus.data);
      end else begin
        e = exp_q.pop_front();
        if (bus.data !== e[DATA_W-1:0] || bus.gnt !== (NUM_REQ'(1) << e[W-1:DATA_W])) begin
          errors++;
          $display("FAIL word cyc=%0d got gnt=%b data=%h expected gnt=%b data=%h", cyc,
                   bus.gnt, bus.data, NUM_REQ'(1) << e[W-1:DATA_W], e[DATA_W-1:0]);
        end
        if (mid_burst) begin
          vectors++;
          if (cyc - last_ack_cyc != 2) begin
            errors++;
            $display("FAIL burst_gap cyc=%0d got=%0d expected=2", cyc, cyc - last_ack_cyc);
          end
        end
        mid_burst = 0;
        live_idx  = int'(e[W-1:DATA_W]);
        live_mid  = (exp_q.size() > 0);
        word_live = 1;
        lcd_busy  = 1;
        lcd_cnt   = $urandom_range(lcd_min, lcd_max);
        issued    = 1;
      end
    end
    if (cyc == inj_at) wr_drv = 1;
    if (lcd_busy && !issued) begin
      if (lcd_cnt == 0) begin
        lcd_busy = 0;
        wr_drv   = 1;
        if (word_live) begin
          ack_due   = 1;
          word_live = 0;
        end
      end else begin
        lcd_cnt--;
      end
    end
    bus.wr_done = wr_drv;
    drive_req();
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((pending_any() || exp_q.size() > 0 || lcd_busy || ack_due) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout got=%0d cycles expected<%0d", name, n, budget);
    end
    step();
    step();
    vectors++;
    if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got gnt=%b busy=%b expected 0/0", name, bus.gnt, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.init_done = 1'b0;
    bus.wr_done   = 1'b0;
    drive_req();
    #5;
    vectors++;
    if ({bus.data, bus.en_write, bus.ack, bus.gnt, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_state got data=%h en=%b ack=%b gnt=%b busy=%b expected all 0",
               bus.data, bus.en_write, bus.ack, bus.gnt, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    vectors++;
    if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got gnt=%b busy=%b expected 0/0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_init_mask();
    bit bad = 0;
    bus.init_done = 1'b0;
    rq[1].push_back({1'b1, 9'h0AA});
    rq[2].push_back({1'b1, 9'h155});
    drive_req();
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.en_write !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL init_mask got grant/busy while init_done=0 expected none");
    end
    rq[0].push_back({1'b1, 9'h011});
    drive_req();
    step();
    vectors++;
    if (bus.en_write !== 1'b1 || bus.gnt !== 3'b001 || bus.data !== 9'h011) begin
      errors++;
      $display("FAIL init_first got en=%b gnt=%b data=%h expected 1/001/011",
               bus.en_write, bus.gnt, bus.data);
    end
    step();
    vectors++;
    if (bus.en_write !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL en_pulse got en=%b busy=%b expected 0/1", bus.en_write, bus.busy);
    end
    drain("init0", 200);
    obs_q.delete();
    bus.init_done = 1'b1;
    drain("init12", 200);
    vectors++;
    if (obs_q.size() != 2 || obs_q[0] !== 3'b010 || obs_q[1] !== 3'b100) begin
      errors++;
      $display("FAIL unmask_order got n=%0d first=%b expected 010 then 100", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 3'b000);
    end
  endtask

  task automatic test_back_to_back();
    int en0 = en_count;
    obs_q.delete();
    rq[1].push_back({1'b0, 9'h02A});
    rq[1].push_back({1'b0, 9'h100});
    rq[1].push_back({1'b1, 9'h1EF});
    rq[2].push_back({1'b1, 9'h033});
    drive_req();
    drain("burst", 300);
    vectors++;
    if (en_count - en0 != 4 || obs_q.size() != 2 || obs_q[0] !== 3'b010 || obs_q[1] !== 3'b100) begin
      errors++;
      $display("FAIL burst_lock got en=%0d bursts=%0d expected 4 words in bursts 010,100",
               en_count - en0, obs_q.size());
    end
  endtask

  task automatic test_arbitration();
    logic [NUM_REQ-1:0] want [5];
`ifdef LCD_ARB_RR_EN
    want = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`else
    want = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    obs_q.delete();
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 5; j++) rq[i].push_back({1'b1, 9'($urandom_range(0, 511))});
    drive_req();
    drain("arb", 1000);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (obs_q.size() <= k || obs_q[k] !== want[k]) begin
        errors++;
        $display("FAIL arb_order idx=%0d got=%b expected=%b", k,
                 obs_q.size() > k ? obs_q[k] : 3'b000, want[k]);
      end
    end
  endtask

  task automatic test_abandon();
    int n = 0;
    rq[2].push_back({1'b0, 9'h0C3});
    rq[2].push_back({1'b0, 9'h03C});
    drive_req();
    while (bus.en_write !== 1'b1 && n < 20) begin step(); n++; end
    rq[1].push_back({1'b1, 9'h1A5});
    drive_req();
    while (rq[2].size() > 0 && n < 100) begin step(); n++; end
    vectors++;
    if (n >= 100) begin
      errors++;
      $display("FAIL abandon_timeout got=%0d expected<100", n);
    end
    step();
    vectors++;
    if (bus.gnt !== 3'b100 || bus.en_write !== 1'b0) begin
      errors++;
      $display("FAIL abandon_hold got gnt=%b en=%b expected 100/0", bus.gnt, bus.en_write);
    end
    step();
    vectors++;
    if (bus.gnt !== 3'b000 || bus.en_write !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abandon_release got gnt=%b en=%b busy=%b expected 000/0/0",
               bus.gnt, bus.en_write, bus.busy);
    end
    step();
    vectors++;
    if (bus.gnt !== 3'b010 || bus.en_write !== 1'b1) begin
      errors++;
      $display("FAIL abandon_next got gnt=%b en=%b expected 010/1", bus.gnt, bus.en_write);
    end
    drain("abandon", 200);
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    bit bad = 0;
    lcd_min = 6;
    lcd_max = 6;
    rq[1].push_back({1'b1, 9'h0F0});
    drive_req();
    while (bus.en_write !== 1'b1 && n < 20) begin step(); n++; end
    step();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.data, bus.en_write, bus.ack, bus.gnt, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait got data=%h en=%b ack=%b gnt=%b busy=%b expected all 0",
               bus.data, bus.en_write, bus.ack, bus.gnt, bus.busy);
    end
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    word_live = 0;
    ack_due   = 0;
    mid_burst = 0;
    mptr      = NUM_REQ - 1;
    drive_req();
    #3 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.gnt !== '0 || bus.busy !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad || lcd_busy) begin
      errors++;
      $display("FAIL late_wr_done got activity=%b lcd_pending=%b expected 0/0", bad, lcd_busy);
    end
    lcd_min = 0;
    lcd_max = 3;
  endtask

  task automatic test_stray_wr_done();
    bit bad = 0;
    int en0;
    inj_at = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.en_write !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL stray_idle got state change on idle wr_done expected none");
    end
    en0 = en_count;
    inj_hold = 1;
    rq[0].push_back({1'b0, 9'h1C0});
    rq[0].push_back({1'b0, 9'h0C1});
    rq[0].push_back({1'b1, 9'h1C2});
    drive_req();
    drain("stray_hold", 300);
    inj_hold = 0;
    vectors++;
    if (en_count - en0 != 3) begin
      errors++;
      $display("FAIL stray_hold_words got=%0d expected=3", en_count - en0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      bus.init_done = ($urandom_range(0, 3) != 0);
      lcd_max = $urandom_range(0, 5);
      for (int i = 0; i < NUM_REQ; i++) begin
        int nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          int nw = $urandom_range(1, 3);
          for (int w = 0; w < nw; w++)
            rq[i].push_back({w == nw - 1, 9'($urandom_range(0, 511))});
        end
      end
      drive_req();
      drain("random", 2000);
    end
    bus.init_done = 1'b1;
    drain("random_tail", 2000);
  endtask

  initial begin
    test_reset();
    test_init_mask();
    test_back_to_back();
    test_arbitration();
    test_abandon();
    test_reset_in_wait();
    test_stray_wr_done();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
